// File: rtl/risc16_mem_arbiter.sv
// Serialises fetch (read-only) and load/store accesses onto one single-port word memory via req/ack.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants under contention; default is data-over-fetch priority.
module risc16_mem_arbiter #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req,
    input  logic [WORD_LENGTH-1:0] i_addr,
    output logic                   i_ack,
    output logic [WORD_LENGTH-1:0] i_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [WORD_LENGTH-1:0] d_addr,
    input  logic [WORD_LENGTH-1:0] d_wdata,
    output logic                   d_ack,
    output logic [WORD_LENGTH-1:0] d_rdata,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [WORD_LENGTH-1:0] mem_din,
    output logic                   mem_we,
    input  logic [WORD_LENGTH-1:0] mem_dout,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    state_t                 state, state_nxt;
    logic                   owner;
    logic                   last_owner;
    logic [WORD_LENGTH-1:0] lat_addr;
    logic [WORD_LENGTH-1:0] lat_wdata;
    logic                   lat_we;
    logic                   grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    // Under contention, data wins only if fetch won the previous access.
    assign grant_data = d_req && (!i_req || last_owner == FETCH);
`else
    assign grant_data = d_req;
`endif

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_din   = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req || i_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = DONE;
                mem_addr  = lat_addr;
                mem_din   = lat_we ? lat_wdata : '0;
                // Gating with rst keeps a store interrupted by reset from reaching memory.
                mem_we    = lat_we && !rst;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= FETCH;
            last_owner <= FETCH;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nxt;
            i_ack <= (state == ACCESS) && (owner == FETCH);
            d_ack <= (state == ACCESS) && (owner == DATA);

            if (state == IDLE && (d_req || i_req)) begin
                owner     <= grant_data ? DATA : FETCH;
                lat_addr  <= grant_data ? d_addr : i_addr;
                lat_wdata <= grant_data ? d_wdata : '0;
                lat_we    <= grant_data && d_we;
            end

            if (state == ACCESS) begin
                if (owner == FETCH) begin
                    i_rdata <= mem_dout;
                end else if (!lat_we) begin
                    d_rdata <= mem_dout;
                end
            end

            if (state == DONE) begin
                last_owner <= owner;
            end
        end
    end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Bench for risc16_mem_arbiter: directed cases plus randomized traffic against a
// transaction-level model (shadow memory, expected read data, expected grant order).
module tb_risc16_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic [15:0] mem_dout;
    logic        busy;

    risc16_mem_arbiter #(.WORD_LENGTH(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on falling edge.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    assign mem_dout = mem[mem_addr];
    always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_din;

    int          total = 0;
    int          passed = 0;
    logic [15:0] exp_i_rdata = '0;
    logic [15:0] exp_d_rdata = '0;
    bit          last_data = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completed access: update the shadow model and compare both read-data outputs.
    task automatic retire(input bit is_d, input bit we, input logic [15:0] a, input logic [15:0] wd);
        if (is_d && we) ref_mem[a] = wd;
        else if (is_d) exp_d_rdata = ref_mem[a];
        else exp_i_rdata = ref_mem[a];
        last_data = is_d;
        check("i_rdata", 32'(i_rdata), 32'(exp_i_rdata));
        check("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
        if (is_d && we) check("store_commit", 32'(mem[a]), 32'(wd));
    endtask

    task automatic single(input bit is_d, input bit we, input logic [15:0] a, input logic [15:0] wd);
        int n = 0;
        int we_cnt = 0;
        bit other = 1'b0;
        bit got = 1'b0;
        if (is_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else begin i_req = 1; i_addr = a; end
        while (!got && n < 8) begin
            step();
            n++;
            if (mem_we) we_cnt++;
            if (is_d ? i_ack : d_ack) other = 1'b1;
            got = is_d ? d_ack : i_ack;
        end
        d_req = 0;
        i_req = 0;
        check("latency", 32'(n), 32'd2);
        check("other_ack", 32'(other), 32'd0);
        check("mem_we_cycles", 32'(we_cnt), (is_d && we) ? 32'd1 : 32'd0);
        if (got) retire(is_d, we, a, wd);
        step();
        check("idle_after", {30'd0, busy, i_ack | d_ack}, 32'd0);
    endtask

    task automatic both(input bit dwe, input logic [15:0] da, input logic [15:0] dwd, input logic [15:0] ia);
        int n = 0;
        int t_d = -1;
        int t_i = -1;
        bit win_d;
`ifdef ARB_ROUND_ROBIN_EN
        win_d = !last_data;
`else
        win_d = 1'b1;
`endif
        d_req = 1; d_we = dwe; d_addr = da; d_wdata = dwd;
        i_req = 1; i_addr = ia;
        while ((t_d < 0 || t_i < 0) && n < 16) begin
            step();
            n++;
            if (d_ack && t_d < 0) begin t_d = n; d_req = 0; retire(1'b1, dwe, da, dwd); end
            if (i_ack && t_i < 0) begin t_i = n; i_req = 0; retire(1'b0, 1'b0, ia, 16'd0); end
        end
        d_req = 0;
        i_req = 0;
        check("winner_latency", 32'(win_d ? t_d : t_i), 32'd2);
        check("loser_latency", 32'(win_d ? t_i : t_d), 32'd5);
        step();
        check("idle_after_pair", 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'h1111; ref_mem[16'h0020] = 16'h1111;
        mem[16'hFFFF] = 16'h7FFF; ref_mem[16'hFFFF] = 16'h7FFF;

        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_i_rdata", 32'(i_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_mem_bus", {mem_addr, mem_din}, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 0;
        step();

        single(1'b0, 1'b0, 16'h0010, 16'h0000);          // fetch 0xBEEF
        single(1'b1, 1'b1, 16'h1234, 16'hA5A5);          // store
        single(1'b1, 1'b0, 16'h1234, 16'h0000);          // load back
        single(1'b1, 1'b0, 16'hFFFF, 16'h0000);          // top address
        single(1'b0, 1'b0, 16'h0003, 16'h0000);          // fetch keeps d_rdata

        for (int r = 0; r < 4; r++) both(1'b0, 16'(r), 16'h0000, 16'(r + 8));

        // Reset arriving during a store's ACCESS cycle.
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'hDEAD;
        step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1;
        #1;
        check("rst_gates_we", 32'(mem_we), 32'd0);
        step();
        check("midrst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdata", {i_rdata, d_rdata}, 32'd0);
        check("midrst_mem_bus", {mem_addr, mem_din}, 32'd0);
        d_req = 0;
        rst = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        last_data = 1'b0;
        step();
        check("store_aborted", 32'(mem[16'h0020]), 32'(ref_mem[16'h0020]));

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: single(1'b0, 1'b0, rand_addr(), 16'h0000);
                1: single(1'b1, 1'b0, rand_addr(), 16'h0000);
                2: single(1'b1, 1'b1, rand_addr(), 16'($urandom));
                default: both(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), rand_addr());
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/risc16_mem_arbiter.md
Name: risc16_mem_arbiter

Overview:
- Shares the single-port RiSC-16 word memory between two requesters: the instruction fetch port (read-only) and the load/store data port (read/write).
- The memory has a combinational read and commits writes on the falling clock edge.
- Sits between the core and the memory instance. Serialises accesses with a req/ack handshake, one access at a time, and returns registered read data.

Parameters:
- WORD_LENGTH, 16, width of address and data words.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request; held high with i_addr stable until i_ack.
- i_addr  in  WORD_LENGTH  fetch address.
- i_ack  out  1  one-cycle pulse: fetch access complete, i_rdata valid.
- i_rdata  out  WORD_LENGTH  fetched word; holds until the next fetch ack.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WORD_LENGTH  data address.
- d_wdata  in  WORD_LENGTH  store data.
- d_ack  out  1  one-cycle pulse: data access complete (load data valid or store committed).
- d_rdata  out  WORD_LENGTH  loaded word; holds until the next load ack.
- mem_addr  out  WORD_LENGTH  memory address.
- mem_din  out  WORD_LENGTH  memory write data.
- mem_we  out  1  memory write enable, sampled by the memory on negedge.
- mem_dout  in  WORD_LENGTH  memory combinational read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, DONE. Encoding is free.
- Reset (posedge with rst=1):
  - state=IDLE, i_ack=d_ack=0, i_rdata=d_rdata=0, last_owner=FETCH.
  - Latched addr/wdata/we = 0.
  - mem_we is gated with !rst, so it is 0 during any cycle with rst high, even mid-ACCESS.
- IDLE:
  - If d_req or i_req is sampled high, latch the winner's address, write data and we (fetch: we=0), record owner, go to ACCESS.
  - Otherwise stay in IDLE.
- Default arbitration: fixed priority, data over fetch.
- ACCESS (exactly one cycle):
  - mem_addr = latched address.
  - mem_we = latched we; the memory commits on this cycle's negedge.
  - mem_din = latched wdata when we=1, else 0.
  - At the closing posedge: if owner=FETCH, i_rdata <= mem_dout. If owner=DATA and we=0, d_rdata <= mem_dout. If owner=DATA and we=1, d_rdata holds.
  - Assert the owner's ack register. Go to DONE.
- DONE (exactly one cycle):
  - The owner's ack is high. Update last_owner.
  - Clear ack at the closing posedge. Go to IDLE.
- Outside ACCESS: mem_addr=0, mem_din=0, mem_we=0.
- Latency: req first sampled at posedge k → ack high during cycle k+2.
  - Throughput: one access per 3 cycles per arbiter.
  - A requester may keep req high with new operands after seeing ack; that is treated as a new request.
- Requests that change or drop while not in IDLE are ignored. Operands are only latched in IDLE.
- Simultaneous i_req and d_req: the loser keeps its req high and is served in the next IDLE cycle. No request is lost.
- Address wrap-around: none. The address is passed through unmodified, so 0xFFFF is valid.
- Reset mid-ACCESS with a store:
  - mem_we is forced low, so no write occurs.
  - No ack is issued.
  - The requester must reissue.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: when both requests are present in IDLE, the grant goes to the owner that did not win last time, per last_owner (reset value FETCH, so data wins first). A lone request is always granted immediately.
- Macro undefined: fixed priority, data over fetch. last_owner is still tracked but not used.

Test Plan:
- Fetch only: preload mem[0x0010]=0xBEEF; i_req=1, i_addr=0x0010 at posedge k → i_ack=1 in cycle k+2, i_rdata=0xBEEF, d_ack=0 throughout.
- Store then load: d_req, d_we=1, d_addr=0x1234, d_wdata=0xA5A5 → d_ack after 2 cycles, mem[0x1234]=0xA5A5. Then a load from 0x1234 → d_rdata=0xA5A5. During the store's ACCESS, mem_we is high for exactly one cycle.
- Contention, macro off: i_req and d_req raised in the same cycle, both held → data acked first at k+2, fetch at k+5. Repeat 3 times: data always wins.
- Contention, ARB_ROUND_ROBIN_EN: both held continuously for 4 accesses → ack order is data, fetch, data, fetch.
- Reset mid-store: rst=1 during the ACCESS cycle of a store to 0x0020 (old value 0x1111) → mem[0x0020] stays 0x1111. No ack; busy=0, all outputs 0 after that posedge.
- Boundary address: load from 0xFFFF holding 0x7FFF → d_rdata=0x7FFF. Then a fetch → d_rdata still 0x7FFF.
